// File: rtl/alu_sched_pkg.sv
// Shared encodings for the ALU round-robin scheduler: ALU op codes and FSM states.
package alu_sched_pkg;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one pipelined ALU between two requesters: grant, issue, wait ALU_LAT edges, respond.
// Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
// the response holds o_rsp_valid, o_rsp_data and o_rsp_id stable until that edge.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int N_BITS  = 32,
  parameter int ALU_LAT = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [1:0]        i_req0_op,
  input  logic [N_BITS-1:0] i_req0_a,
  input  logic [N_BITS-1:0] i_req0_b,
  input  logic [1:0]        i_req1_op,
  input  logic [N_BITS-1:0] i_req1_a,
  input  logic [N_BITS-1:0] i_req1_b,
  output logic [1:0]        o_alu_operation,
  output logic [N_BITS-1:0] o_alu_data_a,
  output logic [N_BITS-1:0] o_alu_data_b,
  output logic              o_alu_valid,
  input  logic [N_BITS-1:0] i_alu_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [N_BITS-1:0] o_rsp_data,
  output logic              o_rsp_id,
  output logic              o_busy
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t              state_q, state_d;
  logic                rr_ptr_q;
  logic [3:0]          cnt_q;
  logic [1:0]          hold_op_q;
  logic [N_BITS-1:0]   hold_a_q, hold_b_q;
  logic                id_q;
  logic                rsp_valid_q, rsp_id_q;
  logic [N_BITS-1:0]   rsp_data_q;
  logic [1:0]          grant;
  logic                grant_id, xfer;

  rr_arb2 u_arb (
    .valid (i_req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign grant_id = grant[1];
  assign xfer     = (state_q == IDLE) && (grant != 2'b00);

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding registers feed the ALU directly, so operands stay put through WAIT and RESP.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rr_ptr_q    <= 1'b0;
      cnt_q       <= 4'd0;
      hold_op_q   <= 2'b00;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            hold_op_q <= grant_id ? i_req1_op : i_req0_op;
            hold_a_q  <= grant_id ? i_req1_a  : i_req0_a;
            hold_b_q  <= grant_id ? i_req1_b  : i_req0_b;
            id_q      <= grant_id;
            rr_ptr_q  <= ~grant_id;
          end
        end
        ISSUE: cnt_q <= CNT_INIT;
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= i_alu_data;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: if (i_rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_req_ready     = (state_q == IDLE) ? grant : 2'b00;
  assign o_alu_valid     = (state_q == ISSUE);
  assign o_alu_operation = hold_op_q;
  assign o_alu_data_a    = hold_a_q;
  assign o_alu_data_b    = hold_b_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_data      = rsp_data_q;
  assign o_rsp_id        = rsp_id_q;
  assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: default build (ALU_LAT=2) plus an ALU_LAT=3 build on shared inputs.
module tb_alu_rr_sched;
  import alu_sched_pkg::*;

  logic        clk, rst;
  logic [1:0]  req_valid;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_ready;

  logic [1:0]  ready, alu_op, ready3, alu_op3;
  logic [31:0] alu_a, alu_b, alu_data, rsp_data, alu_a3, alu_b3, alu_data3, rsp_data3;
  logic        alu_valid, rsp_valid, rsp_id, busy;
  logic        alu_valid3, rsp_valid3, rsp_id3, busy3;

  int n_checks = 0;
  int n_fail   = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_rr_sched #(.N_BITS(32), .ALU_LAT(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(ready),
    .i_req0_op(req0_op), .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req1_op(req1_op), .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_alu_operation(alu_op), .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
    .o_alu_valid(alu_valid), .i_alu_data(alu_data), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_busy(busy));

  alu_rr_sched #(.N_BITS(32), .ALU_LAT(3)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(ready3),
    .i_req0_op(req0_op), .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req1_op(req1_op), .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_alu_operation(alu_op3), .o_alu_data_a(alu_a3), .o_alu_data_b(alu_b3),
    .o_alu_valid(alu_valid3), .i_alu_data(alu_data3), .o_rsp_valid(rsp_valid3),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data3), .o_rsp_id(rsp_id3), .o_busy(busy3));

  // ALU stand-ins: inputs re-registered every edge, result after ALU_LAT edges.
  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a + b;
    endcase
  endfunction

  logic [31:0] pipe2 [2];
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe2[0] <= alu_f(alu_op, alu_a, alu_b);
    pipe2[1] <= pipe2[0];
    pipe3[0] <= alu_f(alu_op3, alu_a3, alu_b3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign alu_data  = pipe2[1];
  assign alu_data3 = pipe3[2];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one request in the current cycle and waits for its response (one accept edge follows).
  task automatic do_op(input bit use3, input logic id, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] rdy, output logic [31:0] data,
                       output logic rid, output int lat);
    lat  = -1;
    data = 'x;
    rid  = 1'bx;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_op = op; req0_a = a; req0_b = b; end
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    rdy = use3 ? ready3 : ready;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) req_valid = 2'b00;
      if (use3 ? rsp_valid3 : rsp_valid) begin
        lat  = i;
        data = use3 ? rsp_data3 : rsp_data;
        rid  = use3 ? rsp_id3 : rsp_id;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b, expected 00", ready); end
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid: got %b, expected 0", alu_valid); end
    n_checks++; if ({alu_op, alu_a, alu_b} !== 66'd0) begin n_fail++; $display("FAIL reset_alu_bus: got %h/%h/%h, expected 0", alu_op, alu_a, alu_b); end
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== 34'd0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b/%h, expected 0", rsp_valid, rsp_id, rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if ({ready3, busy3, rsp_valid3} !== 4'd0) begin n_fail++; $display("FAIL reset_lat3: got %b/%b/%b, expected 0", ready3, busy3, rsp_valid3); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req0_op = OP_ADD; req0_a = 32'h0000_0005; req0_b = 32'h0000_0007;
    req_valid = 2'b01;
    #1;
    n_checks++; if (ready !== 2'b01) begin n_fail++; $display("FAIL single_ready_T: got %b, expected 01", ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL single_alu_valid_T1: got %b, expected 1", alu_valid); end
    n_checks++; if ({alu_op, alu_a, alu_b} !== {OP_ADD, 32'h5, 32'h7}) begin n_fail++; $display("FAIL single_alu_bus_T1: got %h/%h/%h, expected 3/5/7", alu_op, alu_a, alu_b); end
    n_checks++; if (busy !== 1'b1 || ready !== 2'b00) begin n_fail++; $display("FAIL single_busy_T1: got %b/%b, expected 1/00", busy, ready); end
    tick();
    n_checks++; if (alu_valid !== 1'b0 || alu_a !== 32'h5) begin n_fail++; $display("FAIL single_hold_T2: got %b/%h, expected 0/5", alu_valid, alu_a); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_T3: got %b, expected 0", rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid_T4: got %b, expected 1", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0000_000C || rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp_T4: got %h/%b, expected 0000000c/0", rsp_data, rsp_id); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_T5: got %b/%b, expected 0/0", rsp_valid, busy); end
    n_checks++; if (alu_a !== 32'h5 || alu_b !== 32'h7) begin n_fail++; $display("FAIL single_retain_idle: got %h/%h, expected 5/7", alu_a, alu_b); end
  endtask

  task automatic test_contention();
    logic exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int w, n;
    apply_reset();
    rsp_ready = 1'b1;
    req0_op = OP_ADD; req0_a = 32'h3;  req0_b = 32'h4;
    req1_op = OP_XOR; req1_a = 32'hF0; req1_b = 32'h0F;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (ready === 2'b00 && w < 20) begin tick(); w++; end
      n_checks++; if (ready !== (exp_id[k] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b, expected id %0d", k, ready, exp_id[k]); end
      if (k > 0) begin
        n_checks++; if (w !== 0) begin n_fail++; $display("FAIL contention_regrant[%0d]: got %0d idle cycles, expected 0", k, w); end
      end
      n = 0;
      do begin tick(); n++; end while (rsp_valid !== 1'b1 && n < 20);
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL contention_latency[%0d]: got %0d, expected 4", k, n); end
      n_checks++; if (rsp_id !== exp_id[k] || rsp_data !== (exp_id[k] ? 32'hFF : 32'h7)) begin
        n_fail++; $display("FAIL contention_rsp[%0d]: got %b/%h, expected %b/%h", k, rsp_id, rsp_data, exp_id[k], exp_id[k] ? 32'hFF : 32'h7);
      end
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_wrap_ops();
    logic [1:0]  rdy;
    logic [31:0] data;
    logic        rid;
    int          lat;
    logic        v_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  v_op  [4] = '{OP_ADD, OP_XOR, OP_AND, OP_OR};
    logic [31:0] v_a   [4] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    logic [31:0] v_b   [4] = '{32'h0000_0001, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    logic [31:0] v_exp [4] = '{32'h0000_0000, 32'h5A5A_A5A5, 32'hA5A5_0000, 32'hFFFF_A5A5};
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_op(1'b0, v_id[k], v_op[k], v_a[k], v_b[k], rdy, data, rid, lat);
      n_checks++; if (rdy !== (v_id[k] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL ops_ready[%0d]: got %b, expected id %0d", k, rdy, v_id[k]); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ops_latency[%0d]: got %0d, expected 4", k, lat); end
      n_checks++; if (data !== v_exp[k]) begin n_fail++; $display("FAIL ops_data[%0d]: got %h, expected %h", k, data, v_exp[k]); end
      n_checks++; if (rid !== v_id[k]) begin n_fail++; $display("FAIL ops_id[%0d]: got %b, expected %b", k, rid, v_id[k]); end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_op = OP_OR; req0_a = 32'h0000_1200; req0_b = 32'h0000_0034;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    req1_op = OP_ADD; req1_a = 32'h1; req1_b = 32'h1;
    tick(); tick(); tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_first: got %b/%h/%b, expected 1/00001234/0", rsp_valid, rsp_data, rsp_id); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h/%b, expected 1/00001234/0", i, rsp_valid, rsp_data, rsp_id); end
      n_checks++; if (ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_ready_busy[%0d]: got %b/%b, expected 00/1", i, ready, busy); end
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b/%b, expected 0/0", rsp_valid, busy); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_single_accept: got %b/%b, expected 0/0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    rsp_ready = 1'b1;
    req0_op = OP_ADD; req0_a = 32'h1; req0_b = 32'h1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if (busy !== 1'b1 || alu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_state: got %b/%b, expected 1/0", busy, alu_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({ready, alu_valid, busy, rsp_valid, rsp_id} !== 6'd0) begin n_fail++; $display("FAIL rst_wait_ctrl: got %b/%b/%b/%b/%b, expected 0", ready, alu_valid, busy, rsp_valid, rsp_id); end
    n_checks++; if ({alu_op, alu_a, alu_b, rsp_data} !== 98'd0) begin n_fail++; $display("FAIL rst_wait_data: got %h/%h/%h/%h, expected 0", alu_op, alu_a, alu_b, rsp_data); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_rsp: got %b, expected 0", seen); end
  endtask

  task automatic test_lat3();
    logic [1:0]  rdy;
    logic [31:0] data;
    logic        rid;
    int          lat;
    apply_reset();
    rsp_ready = 1'b1;
    do_op(1'b1, 1'b0, OP_ADD, 32'h0000_0005, 32'h0000_0007, rdy, data, rid, lat);
    n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL lat3_ready: got %b, expected 01", rdy); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL lat3_latency: got %0d, expected 5", lat); end
    n_checks++; if (data !== 32'h0000_000C || rid !== 1'b0) begin n_fail++; $display("FAIL lat3_rsp: got %h/%b, expected 0000000c/0", data, rid); end
  endtask

  initial begin
    rst = 1'b0; rsp_ready = 1'b0; req_valid = 2'b00;
    req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_op = 2'b00; req1_a = '0; req1_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap_ops();
    test_backpressure();
    test_reset_mid_wait();
    test_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
